acc16_sat: RTL

Registered 16-bit two's-complement accumulator that sits directly downstream of the team's 16-bit ripple-carry adder. It consumes the adder's sum, carry-out and signed-overflow result and closes the loop through a register. Each accepted operand is loaded into, added to or subtracted from the running value, or clears it; the choice is a per-transaction opcode. Optional saturation and a sticky overflow flag make it usable as a datapath accumulator with valid/ready flow control on both sides.

---
 rtl/acc16_pkg.sv | 16 +
 rtl/add16_flags.sv | 29 ++
 rtl/acc16_sat.sv | 125 ++++++++++++
 3 files changed

// File: rtl/acc16_pkg.sv
// Shared constants and opcode encoding for the 16-bit saturating accumulator.
package acc16_pkg;

    localparam int WIDTH = 16;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_ADD   = 2'b01,
        OP_SUB   = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    localparam logic [WIDTH-1:0] SAT_POS = 16'h7FFF;
    localparam logic [WIDTH-1:0] SAT_NEG = 16'h8000;

endpackage

// File: rtl/add16_flags.sv
// Combinational adder returning sum, carry-out and signed overflow.
// The sum is split at the MSB so the carry into the sign bit is visible.
module add16_flags
    import acc16_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    logic [W-1:0] low_s;
    logic         c_msb_s;
    logic         msb_s;
    logic         cout_s;

    assign low_s         = {1'b0, a[W-2:0]} + {1'b0, b[W-2:0]} + {{(W-1){1'b0}}, cin};
    assign c_msb_s       = low_s[W-1];
    assign {cout_s, msb_s} = {1'b0, a[W-1]} + {1'b0, b[W-1]} + {1'b0, c_msb_s};

    assign sum  = {msb_s, low_s[W-2:0]};
    assign cout = cout_s;
    assign ovf  = c_msb_s ^ cout_s;

endmodule

// File: rtl/acc16_sat.sv
// Registered 16-bit accumulator with LOAD/ADD/SUB/CLEAR, optional saturation,
// sticky overflow and a single-slot valid/ready output register.
module acc16_sat
    import acc16_pkg::*;
#(
    parameter int WIDTH = acc16_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_op,
    input  logic             sat_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] acc_out,
    output logic             cout_out,
    output logic             ovf_out,
    output logic             ovf_sticky,
    input  logic             ovf_clr
);

    logic [WIDTH-1:0] acc_r, acc_d_s;
    logic             cout_r, cout_d_s;
    logic             ovf_r, ovf_d_s;
    logic             sticky_r, sticky_d_s;
    logic             valid_r, valid_d_s;

    logic             accept_s;
    logic [WIDTH-1:0] data_s;
    op_e              op_s;
    logic             is_sub_s;
    logic [WIDTH-1:0] add_b_s;
    logic [WIDTH-1:0] add_sum_s;
    logic             add_cout_s;
    logic             add_ovf_s;
    logic             op_ovf_s;

    assign in_ready = ~valid_r | out_ready;
    assign accept_s = in_valid & in_ready;

    // Operands are masked while idle so undriven inputs never reach the adder.
    assign data_s   = in_valid ? in_data : {WIDTH{1'b0}};
    assign op_s     = in_valid ? op_e'(in_op) : OP_LOAD;
    assign is_sub_s = (op_s == OP_SUB);
    assign add_b_s  = is_sub_s ? ~data_s : data_s;

    add16_flags #(.W(WIDTH)) u_add (
        .a    (acc_r),
        .b    (add_b_s),
        .cin  (is_sub_s),
        .sum  (add_sum_s),
        .cout (add_cout_s),
        .ovf  (add_ovf_s)
    );

    // Next-state: opcode mux, saturation, handshake and sticky flag.
    always_comb begin
        acc_d_s   = acc_r;
        cout_d_s  = cout_r;
        ovf_d_s   = ovf_r;
        valid_d_s = valid_r;
        op_ovf_s  = 1'b0;
        if (accept_s) begin
            valid_d_s = 1'b1;
            case (op_s)
                OP_LOAD: begin
                    acc_d_s  = data_s;
                    cout_d_s = 1'b0;
                    ovf_d_s  = 1'b0;
                end
                OP_ADD, OP_SUB: begin
                    op_ovf_s = add_ovf_s;
                    cout_d_s = add_cout_s;
                    ovf_d_s  = add_ovf_s;
                    if (sat_en && add_ovf_s) begin
                        acc_d_s = acc_r[WIDTH-1] ? SAT_NEG : SAT_POS;
                    end else begin
                        acc_d_s = add_sum_s;
                    end
                end
                OP_CLEAR: begin
                    acc_d_s  = {WIDTH{1'b0}};
                    cout_d_s = 1'b0;
                    ovf_d_s  = 1'b0;
                end
                default: begin
                    acc_d_s  = acc_r;
                    cout_d_s = cout_r;
                    ovf_d_s  = ovf_r;
                end
            endcase
        end else if (out_ready) begin
            valid_d_s = 1'b0;
        end else begin
            valid_d_s = valid_r;
        end
        sticky_d_s = (sticky_r & ~ovf_clr) | op_ovf_s;
    end

    // State registers; reset discards any in-flight result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r    <= {WIDTH{1'b0}};
            cout_r   <= 1'b0;
            ovf_r    <= 1'b0;
            sticky_r <= 1'b0;
            valid_r  <= 1'b0;
        end else begin
            acc_r    <= acc_d_s;
            cout_r   <= cout_d_s;
            ovf_r    <= ovf_d_s;
            sticky_r <= sticky_d_s;
            valid_r  <= valid_d_s;
        end
    end

    assign acc_out    = acc_r;
    assign cout_out   = cout_r;
    assign ovf_out    = ovf_r;
    assign ovf_sticky = sticky_r;
    assign out_valid  = valid_r;

endmodule
